// File: rtl/debug_pkg.sv
// Shared opcodes, response codes and FSM state encoding for debug_cmd_sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StMemReq,
    StResp
  } dbg_state_e;

  // Command opcodes accepted in StIdle
  localparam logic [7:0] OpHalt   = 8'h01;
  localparam logic [7:0] OpRun    = 8'h02;
  localparam logic [7:0] OpStep   = 8'h03;
  localparam logic [7:0] OpStatus = 8'h04;
  localparam logic [7:0] OpRead   = 8'h10;
  localparam logic [7:0] OpWrite  = 8'h20;
  localparam logic [7:0] OpSetBp  = 8'h30;

  // Response codes
  localparam logic [7:0] RspOk      = 8'hA5;
  localparam logic [7:0] RspBadOp   = 8'hEE;
  localparam logic [7:0] RspStepErr = 8'hE1;
  localparam logic [7:0] RspTimeout = 8'hE2;

endpackage

// File: rtl/debug_timeout.sv
// Memory-access watchdog: load arms it, count ticks it down, expired flags the last cycle.
module debug_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt_q;

  // Loaded with TIMEOUT-1 so expired is high on the TIMEOUT-th counting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= 8'(TIMEOUT - 1);
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Byte-serial debug command sequencer: halt/run/step a microcode engine and access its memory.
// Optional breakpoint support is compiled in with `define DBG_BREAKPOINT_EN.
module debug_cmd_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready,
  output logic              core_halt,
  output logic              core_step,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  dbg_state_e        state_q, state_d;
  logic              core_halt_q, core_halt_d;
  logic              core_step_q, core_step_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [7:0]        op_q, op_d;
  logic              tmo_load, tmo_count, tmo_expired;
`ifdef DBG_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_armed_q, bp_armed_d;
`endif

  debug_timeout #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmo_load),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      core_halt_q <= 1'b1;
      core_step_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      op_q        <= '0;
`ifdef DBG_BREAKPOINT_EN
      bp_addr_q   <= '0;
      bp_armed_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      core_halt_q <= core_halt_d;
      core_step_q <= core_step_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      op_q        <= op_d;
`ifdef DBG_BREAKPOINT_EN
      bp_addr_q   <= bp_addr_d;
      bp_armed_q  <= bp_armed_d;
`endif
    end
  end

  // Command decode, memory handshake and response next-state; everything freezes while ena=0
  always_comb begin
    state_d     = state_q;
    core_halt_d = core_halt_q;
    core_step_d = core_step_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    op_d        = op_q;
    tmo_load    = 1'b0;
    tmo_count   = 1'b0;
`ifdef DBG_BREAKPOINT_EN
    bp_addr_d   = bp_addr_q;
    bp_armed_d  = bp_armed_q;
`endif
    if (ena) begin
      core_step_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_d       = cmd_data;
            state_d    = StResp;
            rsp_data_d = RspOk;
            case (cmd_data)
              OpHalt:   core_halt_d = 1'b1;
              OpRun:    core_halt_d = 1'b0;
              OpStep: begin
                if (core_halt_q) core_step_d = 1'b1;
                else             rsp_data_d  = RspStepErr;
              end
              OpStatus: rsp_data_d = 8'(core_pc);
              OpRead, OpWrite, OpSetBp: state_d = StGetAddr;
              default:  rsp_data_d = RspBadOp;
            endcase
          end
        end
        StGetAddr: begin
          if (cmd_valid) begin
            if (op_q == OpSetBp) begin
`ifdef DBG_BREAKPOINT_EN
              bp_addr_d  = ADDR_W'(cmd_data);
              bp_armed_d = 1'b1;
              rsp_data_d = RspOk;
`else
              rsp_data_d = RspBadOp;
`endif
              state_d = StResp;
            end else begin
              mem_addr_d = ADDR_W'(cmd_data);
              if (op_q == OpWrite) begin
                state_d = StGetData;
              end else begin
                mem_we_d  = 1'b0;
                mem_req_d = 1'b1;
                tmo_load  = 1'b1;
                state_d   = StMemReq;
              end
            end
          end
        end
        StGetData: begin
          if (cmd_valid) begin
            mem_wdata_d = cmd_data;
            mem_we_d    = 1'b1;
            mem_req_d   = 1'b1;
            tmo_load    = 1'b1;
            state_d     = StMemReq;
          end
        end
        StMemReq: begin
          tmo_count = 1'b1;
          // An ack on the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            mem_req_d  = 1'b0;
            rsp_data_d = mem_we_q ? RspOk : mem_rdata;
            state_d    = StResp;
          end else if (tmo_expired) begin
            mem_req_d  = 1'b0;
            rsp_data_d = RspTimeout;
            state_d    = StResp;
          end
        end
        StResp: begin
          if (rsp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
`ifdef DBG_BREAKPOINT_EN
      // Breakpoint hit overrides a RUN accepted in the same cycle
      if (bp_armed_q && !core_halt_q && (core_pc == bp_addr_q)) begin
        core_halt_d = 1'b1;
        bp_armed_d  = 1'b0;
      end
`endif
    end
  end

  assign cmd_ready = ena && ((state_q == StIdle) || (state_q == StGetAddr) ||
                             (state_q == StGetData));
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign core_halt = core_halt_q;
  assign core_step = core_step_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: directed scenarios plus randomized command stream
// checked against a command-level reference model and a behavioural debug memory.
`timescale 1ns/1ps
module tb_debug_cmd_sequencer;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_data = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_ready = 1'b0;
  logic          core_halt;
  logic          core_step;
  logic [AW-1:0] core_pc = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;

  debug_cmd_sequencer #(
    .ADDR_W      (AW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .core_halt (core_halt),
    .core_step (core_step),
    .core_pc   (core_pc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;

  // Environment / monitor state
  logic [7:0] dev_mem   [256];
  logic [7:0] model_mem [256];
  bit         ack_never = 1'b0;
  int         ack_delay = 1;
  int         req_run = 0;
  int         req_hi = 0;
  int         step_pulses = 0;
  bit         req_unstable = 1'b0;
  logic [7:0] seen_addr = '0;
  logic [7:0] seen_wdata = '0;
  logic       seen_we = 1'b0;

  // Reference model state
  bit         m_halted = 1'b1;
  bit         m_armed = 1'b0;
  logic [7:0] m_bp = '0;

  // Debug memory device plus monitor; acks after ack_delay request cycles, noisy acks when idle
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (core_step === 1'b1) step_pulses++;
      if (mem_req === 1'b1) begin
        if (req_run == 0) begin
          seen_addr  = mem_addr;
          seen_we    = mem_we;
          seen_wdata = mem_wdata;
        end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata) begin
          req_unstable = 1'b1;
        end
        req_run++;
        req_hi++;
        if (!ack_never && req_run == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = dev_mem[mem_addr];
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = 8'($urandom);
        end
      end else begin
        req_run   = 0;
        mem_ack   = ($urandom_range(3) == 0);
        mem_rdata = 8'($urandom);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold, output logic [7:0] d);
    int n = 0;
    bit stable = 1'b1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    d = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_rsp_stable"}, 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // Command-level reference: expected response and step pulses from the opcode rules
  task automatic model_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rsp, output int pulses);
    pulses = 0;
    case (op)
      8'h01: begin m_halted = 1'b1; rsp = 8'hA5; end
      8'h02: begin m_halted = 1'b0; rsp = 8'hA5; end
      8'h03: begin
        if (m_halted) begin pulses = 1; rsp = 8'hA5; end
        else rsp = 8'hE1;
      end
      8'h04: rsp = core_pc;
      8'h10: rsp = ack_never ? 8'hE2 : model_mem[a];
      8'h20: begin
        if (ack_never) rsp = 8'hE2;
        else begin model_mem[a] = d; rsp = 8'hA5; end
      end
`ifdef DBG_BREAKPOINT_EN
      8'h30: begin m_bp = a; m_armed = 1'b1; rsp = 8'hA5; end
`else
      8'h30: rsp = 8'hEE;
`endif
      default: rsp = 8'hEE;
    endcase
  endtask

  task automatic exec(input string tag, input logic [7:0] op, input logic [7:0] a,
                      input logic [7:0] d, input int hold);
    logic [7:0] exp_rsp;
    logic [7:0] got;
    int exp_pulses;
    int exp_req;
    bit mem_op;
    mem_op  = (op == 8'h10 || op == 8'h20);
    exp_req = !mem_op ? 0 : (ack_never ? int'(TMO) : ack_delay);
    model_cmd(op, a, d, exp_rsp, exp_pulses);
    req_hi       = 0;
    step_pulses  = 0;
    req_unstable = 1'b0;
    send_byte(op);
    if (op == 8'h10 || op == 8'h20 || op == 8'h30) send_byte(a);
    if (op == 8'h20) send_byte(d);
    get_rsp(tag, hold, got);
    check({tag, "_rsp_data"}, 32'(got), 32'(exp_rsp));
    check({tag, "_step_pulses"}, 32'(step_pulses), 32'(exp_pulses));
    check({tag, "_core_halt"}, 32'(core_halt), 32'(m_halted));
    check({tag, "_req_cycles"}, 32'(req_hi), 32'(exp_req));
    if (mem_op) begin
      check({tag, "_mem_addr"}, 32'(seen_addr), 32'(a));
      check({tag, "_mem_we"}, 32'(seen_we), 32'(op == 8'h20));
      if (op == 8'h20) check({tag, "_mem_wdata"}, 32'(seen_wdata), 32'(d));
      check({tag, "_req_stable"}, 32'(req_unstable), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] op;
    logic [7:0] ra;
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dev_mem[i]   = v;
      model_mem[i] = v;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_core_halt", 32'(core_halt), 32'd1);
    check("rst_core_step", 32'(core_step), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // STATUS after reset
    core_pc = 8'h42;
    exec("status42", 8'h04, 8'h00, 8'h00, 0);

    // WRITE then READ back through the device
    ack_delay = 3;
    exec("write07", 8'h20, 8'h07, 8'h5A, 0);
    exec("read07", 8'h10, 8'h07, 8'h00, 2);

    // READ with no ack: times out after exactly TMO request cycles
    ack_never = 1'b1;
    exec("read_tmo", 8'h10, 8'h33, 8'h00, 0);
    ack_never = 1'b0;

    // STEP halted / RUN / STEP running / HALT
    exec("step_halted", 8'h03, 8'h00, 8'h00, 0);
    exec("run", 8'h02, 8'h00, 8'h00, 0);
    exec("step_running", 8'h03, 8'h00, 8'h00, 0);
    exec("halt", 8'h01, 8'h00, 8'h00, 0);
    exec("bad_op", 8'h55, 8'h00, 8'h00, 1);

    // ena low: nothing accepted, no state change
    @(negedge clk);
    ena       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h02;
    repeat (3) @(negedge clk);
    check("ena_cmd_ready", 32'(cmd_ready), 32'd0);
    check("ena_rsp_valid", 32'(rsp_valid), 32'd0);
    check("ena_core_halt", 32'(core_halt), 32'd1);
    cmd_valid = 1'b0;
    ena       = 1'b1;

    // Reset while WRITE waits for its data byte
    send_byte(8'h20);
    send_byte(8'h33);
    @(negedge clk);
    rst_n  = 1'b0;
    req_hi = 0;
    @(negedge clk);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_core_halt", 32'(core_halt), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_no_req", 32'(req_hi), 32'd0);
    m_halted = 1'b1;
    m_armed  = 1'b0;
    core_pc  = 8'h9C;
    exec("midrst_status", 8'h04, 8'h00, 8'h00, 0);

    // Breakpoint
    core_pc = 8'h00;
    exec("setbp", 8'h30, 8'h10, 8'h00, 0);
`ifdef DBG_BREAKPOINT_EN
    exec("bp_run", 8'h02, 8'h00, 8'h00, 0);
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      core_pc = 8'(p);
    end
    check("bp_before_hit", 32'(core_halt), 32'd0);
    @(posedge clk);
    #1;
    check("bp_hit", 32'(core_halt), 32'd1);
    m_halted = 1'b1;
    m_armed  = 1'b0;
    exec("bp_status", 8'h04, 8'h00, 8'h00, 4);
    exec("bp_rerun", 8'h02, 8'h00, 8'h00, 0);
    repeat (3) @(negedge clk);
    check("bp_disarmed", 32'(core_halt), 32'd0);
    exec("bp_halt", 8'h01, 8'h00, 8'h00, 0);
`else
    exec("nobp_status", 8'h04, 8'h00, 8'h00, 4);
`endif

    // Randomized command stream
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(6))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h10;
        5: op = 8'h20;
        default: begin
          op = 8'($urandom);
          while (op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30}) op = 8'($urandom);
        end
      endcase
      ra        = 8'($urandom);
      rd        = 8'($urandom);
      core_pc   = 8'($urandom);
      ack_never = ($urandom_range(5) == 0);
      ack_delay = int'($urandom_range(12, 1));
      exec($sformatf("rnd%0d_op%02h", n, op), op, ra, rd, int'($urandom_range(3)));
    end
    ack_never = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sequencer.md
DEBUG_CMD_SEQUENCER -- requirements
Module: debug_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: target memory address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: max cycles to wait for mem_ack, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock for all state.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ena, input, 1: when low, FSM holds, no new command accepted, outputs hold.
REQ-006 SHALL have port cmd_valid, input, 1: command byte present.
REQ-007 SHALL have port cmd_data, input, 8: command/operand byte.
REQ-008 SHALL have port cmd_ready, output, 1: byte accepted when cmd_valid&&cmd_ready.
REQ-009 SHALL have port rsp_valid, output, 1: response byte present.
REQ-010 SHALL have port rsp_data, output, 8: response byte.
REQ-011 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid&&rsp_ready.
REQ-012 SHALL have port core_halt, output, 1: level, holds microcode engine stopped.
REQ-013 SHALL have port core_step, output, 1: one-cycle pulse, advances a halted engine one microinstruction.
REQ-014 SHALL have port core_pc, input, ADDR_W: engine's current microcode address.
REQ-015 SHALL have ports mem_req (out,1), mem_we (out,1), mem_addr (out,ADDR_W), mem_wdata (out,8), mem_rdata (in,8), mem_ack (in,1): debug memory access port.

Function
REQ-016 SHALL implement states IDLE, GET_ADDR, GET_DATA, MEM_REQ, RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE, GET_ADDR, GET_DATA with ena=1.
REQ-018 Opcodes in IDLE: 0x01 HALT, 0x02 RUN, 0x03 STEP, 0x04 STATUS, 0x10 READ, 0x20 WRITE, 0x30 SETBP; others -> RESP with 0xEE.
REQ-019 HALT/RUN SHALL set/clear core_halt the cycle after acceptance, then RESP with 0xA5.
REQ-020 STEP SHALL pulse core_step exactly one cycle only if core_halt=1, then RESP 0xA5; if running, no pulse, RESP 0xE1.
REQ-021 STATUS SHALL RESP with core_pc (low 8 bits, zero-extended if ADDR_W<8).
REQ-022 READ/WRITE/SETBP SHALL take next byte as address (GET_ADDR); WRITE additionally takes data byte (GET_DATA).
REQ-023 MEM_REQ SHALL hold mem_req=1 with stable addr/we/wdata until mem_ack; mem_req drops the cycle after ack.
REQ-024 READ SHALL RESP with mem_rdata captured on ack cycle; WRITE SHALL RESP 0xA5.
REQ-025 If no mem_ack within MEM_TIMEOUT cycles of mem_req rising, SHALL drop mem_req and RESP 0xE2.
REQ-026 RESP SHALL hold rsp_valid and rsp_data stable until rsp_ready, then return to IDLE next cycle; back-to-back commands allowed.
REQ-027 mem_ack outside MEM_REQ SHALL be ignored.

Reset
REQ-028 On rst_n low: state IDLE, core_halt=1, core_step=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, breakpoint cleared; applies mid-transaction, partial commands discarded.

Configuration
REQ-029 With DBG_BREAKPOINT_EN defined: SETBP stores address and arms; when core_halt=0 and core_pc equals stored address, core_halt SHALL assert next cycle and breakpoint disarms; SETBP RESP 0xA5.
REQ-030 Without DBG_BREAKPOINT_EN: SETBP consumes its address byte, RESP 0xEE, no breakpoint logic present.

Structure
REQ-031 Opcodes, response codes and state enum SHALL live in package debug_pkg.
REQ-032 Timeout counter SHALL be sub-module debug_timeout (load, count, expire flag).

Verification
REQ-033 Reset then STATUS with core_pc=0x42 -> rsp_data=0x42, core_halt=1.
REQ-034 WRITE 0x20,0x07,0x5A with ack after 3 cycles -> mem_we=1, mem_addr=0x07, mem_wdata=0x5A, rsp 0xA5; READ 0x10,0x07 returning 0x5A -> rsp 0x5A.
REQ-035 READ with mem_ack never asserted -> mem_req high exactly 15 cycles, rsp 0xE2.
REQ-036 STEP while halted -> single core_step pulse, rsp 0xA5; RUN then STEP -> no pulse, rsp 0xE1.
REQ-037 With DBG_BREAKPOINT_EN: SETBP 0x30,0x10, RUN, core_pc ramps to 0x10 -> core_halt=1 one cycle later; rsp_ready held low during RESP keeps rsp_data stable.
REQ-038 rst_n low during GET_DATA of WRITE -> no mem_req, state IDLE, next command decoded normally.
